mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- Load/store unit for the memory stage. It replaces the single-cycle, fixed-size dmem path with a request/response handshake to an external data memory.
- Generalised over memory depth and misalignment policy. It can split misaligned half/word accesses into two word beats instead of faulting.
- Sits between the ex_mb pipeline register and writeback. It stalls upstream while an access is in flight and delivers the extended load data itself.

Parameters:
- MEM_ADDR_W, 11: word-address width on the memory port. Word index wraps modulo 2^MEM_ADDR_W.
- MISALIGN_SPLIT, 1: 1 = misaligned accesses split into two beats; 0 = misaligned accesses fault with no memory traffic.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- ex_mb__valid  in  1  an instruction is present in ex_mb.
- ex_mb__dmem_read  in  1  load.
- ex_mb__dmem_write  in  1  store.
- ex_mb__dmem_width  in  2  ENCDEC_BYTE/HALF/WORD.
- ex_mb__dmem_zero_ext  in  1  zero-extend load (else sign-extend).
- ex_mb__addr  in  32  byte address (alu_y).
- ex_mb__wdata  in  32  store data (rs2), LSB-aligned.
- lsu_stall  out  1  hold ex_mb and earlier stages.
- mb_wb__valid  out  1  access complete, one-cycle pulse.
- mb_wb__rdata  out  32  aligned and extended load result.
- mb_wb__load_misalign  out  1  load fault (MISALIGN_SPLIT=0 only).
- mb_wb__store_misalign  out  1  store fault (MISALIGN_SPLIT=0 only).
- mb_wb__fault_addr  out  32  faulting byte address.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  MEM_ADDR_W  word address.
- mem_req_writeb  out  4  byte enables; 0 = read.
- mem_req_wdata  out  32  write data, lane-positioned.
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_rdata  in  32  read data.

Behaviour:
- Reset: state IDLE; all registered outputs 0; lsu_stall forced 0 while rst is high. Reset mid-operation abandons the access. Memory is reset by the same rst. mem_rsp_valid outside RSP is ignored.
- States: IDLE, REQ, RSP, DONE.
  - Accept in IDLE when ex_mb__valid and (read or write). read and write both high: treated as read.
  - Valid with neither read nor write: no stall, no mb_wb__valid.
- Capture at accept: k = addr[1:0], W = addr[MEM_ADDR_W+1:2], width mask wm = 0001/0011/1111.
  - 8-bit span mask m = wm << k.
  - 64-bit data span = wdata << 8k.
  - Beat 1 is needed iff m[7:4] != 0.
- Fault (MISALIGN_SPLIT=0 and m[7:4] != 0): IDLE->DONE with no request. Misalign flag by access type; fault_addr = addr; rdata = 0.
- REQ beat b (0 or 1):
  - mem_req_valid=1; addr = W+b (wrapped); writeb = m[4b+3:4b] for stores, 0 for loads; wdata = span[32b+31:32b].
  - Payload stable until mem_req_ready. Transition on valid&&ready.
  - Store: next beat, or DONE.
  - Load: RSP.
- RSP: wait mem_rsp_valid (earliest one cycle after acceptance). Latch the beat into lane b. Then REQ beat 1 if needed, else DONE. One outstanding request maximum.
- Load extract: {lane1, lane0} >> 8k, truncate to width, sign/zero extend. lane1 is 0 if beat 1 is unused.
- DONE: mb_wb__valid=1 for one cycle with rdata/flags, then IDLE. The held instruction is not re-accepted in DONE.
- lsu_stall = memory op present and not (state==DONE). It is combinational, so upstream advances in the DONE cycle.
- Latency with zero-wait memory (accept at cycle N):
  - aligned store: valid at N+2.
  - aligned load: valid at N+3.
  - split load: valid at N+5.
  - fault: valid at N+1.

Decomposition:
- Shared header:
  - ENCDEC_* width codes (existing dmem_encdec.vh).
  - LSU state encodings.
- Sub-module lsu_lane_align (combinational). Takes width, k, wdata, zero_ext and the two lanes; produces span mask m, write-data span, beat-1-needed flag, and extended rdata.

Test Plan:
- Word store 0xDEADBEEF to 0x100, ready=1 -> one request: addr 0x40, writeb 1111, wdata 0xDEADBEEF; mb_wb__valid at N+2.
- Byte load 0x103, rsp 0x80112233 -> rdata 0xFFFFFF80; with zero_ext=1 -> rdata 0x00000080.
- Word store 0xAABBCCDD to 0x102, SPLIT=1 -> beat0: addr 0x40, writeb 1100, wdata 0xCCDD0000; beat1: addr 0x41, writeb 0011, wdata 0x0000AABB.
- MEM_ADDR_W=9, half load 0x7FF -> beat0 addr 0x1FF, beat1 addr 0x000. rsp0 0x12000000, rsp1 0x00000034 -> rdata 0x00003412.
- SPLIT=0, word load 0x101 -> no mem_req_valid; at N+1 mb_wb__valid=1, load_misalign=1, fault_addr 0x101.
- Hold ready=0 for 3 cycles -> payload stable and lsu_stall=1 throughout. Then assert rst in RSP -> outputs 0 immediately; a later mem_rsp_valid produces no mb_wb__valid.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: dmem width codes, FSM states
// and the access-width byte mask.
package mem_lsu_pkg;

  localparam logic [1:0] ENCDEC_BYTE = 2'd0;
  localparam logic [1:0] ENCDEC_HALF = 2'd1;
  localparam logic [1:0] ENCDEC_WORD = 2'd2;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RSP  = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_t;

  function automatic logic [3:0] width_mask(input logic [1:0] width);
    case (width)
      ENCDEC_BYTE: width_mask = 4'b0001;
      ENCDEC_HALF: width_mask = 4'b0011;
      default:     width_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_lane_align.sv
// Combinational lane alignment: byte-span mask and write-data span for an
// access at byte offset k, plus extraction/extension of load data from two lanes.
module lsu_lane_align
  import mem_lsu_pkg::*;
(
  input  logic [1:0]  width,
  input  logic [1:0]  k,
  input  logic [31:0] wdata,
  input  logic        zero_ext,
  input  logic [31:0] lane0,
  input  logic [31:0] lane1,
  output logic [7:0]  mask,
  output logic [63:0] span,
  output logic        need1,
  output logic [31:0] rdata
);

  logic [63:0] shifted;

  assign mask    = {4'b0000, width_mask(width)} << k;
  assign span    = {32'h0, wdata} << {k, 3'b000};
  assign need1   = |mask[7:4];
  assign shifted = {lane1, lane0} >> {k, 3'b000};

  always_comb begin
    rdata = shifted[31:0];
    case (width)
      ENCDEC_BYTE: rdata = {{24{~zero_ext & shifted[7]}}, shifted[7:0]};
      ENCDEC_HALF: rdata = {{16{~zero_ext & shifted[15]}}, shifted[15:0]};
      default:     rdata = shifted[31:0];
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: turns an ex_mb memory op into one or two word
// beats on a valid/ready memory port and returns aligned, extended load data.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int MEM_ADDR_W     = 11,
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_mb__valid,
  input  logic                  ex_mb__dmem_read,
  input  logic                  ex_mb__dmem_write,
  input  logic [1:0]            ex_mb__dmem_width,
  input  logic                  ex_mb__dmem_zero_ext,
  input  logic [31:0]           ex_mb__addr,
  input  logic [31:0]           ex_mb__wdata,
  output logic                  lsu_stall,
  output logic                  mb_wb__valid,
  output logic [31:0]           mb_wb__rdata,
  output logic                  mb_wb__load_misalign,
  output logic                  mb_wb__store_misalign,
  output logic [31:0]           mb_wb__fault_addr,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [MEM_ADDR_W-1:0] mem_req_addr,
  output logic [3:0]            mem_req_writeb,
  output logic [31:0]           mem_req_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [31:0]           mem_rsp_rdata
);

  lsu_state_t state, state_nx;
  logic        beat, beat_nx;
  logic        accept, lat0, lat1;
  logic [31:0] addr_q, wdata_q, lane0_q, lane1_q;
  logic [1:0]  width_q;
  logic        zext_q, is_load_q, fault_q;

  logic        mem_op, in_idle, done;
  logic [7:0]  mask;
  logic [63:0] span;
  logic        need1;
  logic [31:0] ext_rdata;
  logic [MEM_ADDR_W-1:0] word_addr;

  assign mem_op  = ex_mb__valid & (ex_mb__dmem_read | ex_mb__dmem_write);
  assign in_idle = (state == LSU_IDLE);
  assign done    = (state == LSU_DONE);

  // In IDLE the aligner looks at the live instruction so the fault decision
  // can be made at accept; afterwards it works from the captured copy.
  lsu_lane_align u_align (
    .width    (in_idle ? ex_mb__dmem_width : width_q),
    .k        (in_idle ? ex_mb__addr[1:0]  : addr_q[1:0]),
    .wdata    (in_idle ? ex_mb__wdata      : wdata_q),
    .zero_ext (zext_q),
    .lane0    (lane0_q),
    .lane1    (lane1_q),
    .mask     (mask),
    .span     (span),
    .need1    (need1),
    .rdata    (ext_rdata)
  );

  assign word_addr = addr_q[MEM_ADDR_W+1:2] + {{(MEM_ADDR_W-1){1'b0}}, beat};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LSU_IDLE;
      beat  <= 1'b0;
    end else begin
      state <= state_nx;
      beat  <= beat_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    beat_nx        = beat;
    accept         = 1'b0;
    lat0           = 1'b0;
    lat1           = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_addr   = '0;
    mem_req_writeb = 4'b0000;
    mem_req_wdata  = 32'h0;
    case (state)
      LSU_IDLE: begin
        if (mem_op) begin
          accept   = 1'b1;
          beat_nx  = 1'b0;
          state_nx = ((MISALIGN_SPLIT == 0) && need1) ? LSU_DONE : LSU_REQ;
        end
      end
      LSU_REQ: begin
        mem_req_valid  = 1'b1;
        mem_req_addr   = word_addr;
        mem_req_writeb = is_load_q ? 4'b0000 : (beat ? mask[7:4] : mask[3:0]);
        mem_req_wdata  = beat ? span[63:32] : span[31:0];
        if (mem_req_ready) begin
          if (is_load_q)            state_nx = LSU_RSP;
          else if (!beat && need1)  beat_nx  = 1'b1;
          else                      state_nx = LSU_DONE;
        end
      end
      LSU_RSP: begin
        if (mem_rsp_valid) begin
          lat0 = ~beat;
          lat1 = beat;
          if (!beat && need1) begin
            state_nx = LSU_REQ;
            beat_nx  = 1'b1;
          end else begin
            state_nx = LSU_DONE;
          end
        end
      end
      default: state_nx = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      width_q   <= 2'b00;
      zext_q    <= 1'b0;
      is_load_q <= 1'b0;
      fault_q   <= 1'b0;
      lane0_q   <= 32'h0;
      lane1_q   <= 32'h0;
    end else if (accept) begin
      addr_q    <= ex_mb__addr;
      wdata_q   <= ex_mb__wdata;
      width_q   <= ex_mb__dmem_width;
      zext_q    <= ex_mb__dmem_zero_ext;
      is_load_q <= ex_mb__dmem_read;
      fault_q   <= (MISALIGN_SPLIT == 0) && need1;
      lane0_q   <= 32'h0;
      lane1_q   <= 32'h0;
    end else begin
      if (lat0) lane0_q <= mem_rsp_rdata;
      if (lat1) lane1_q <= mem_rsp_rdata;
    end
  end

  assign mb_wb__valid          = done;
  assign mb_wb__rdata          = (done && !fault_q) ? ext_rdata : 32'h0;
  assign mb_wb__load_misalign  = done & fault_q & is_load_q;
  assign mb_wb__store_misalign = done & fault_q & ~is_load_q;
  assign mb_wb__fault_addr     = (done && fault_q) ? addr_q : 32'h0;
  assign lsu_stall             = ~rst & mem_op & ~done;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboarded bench for mem_lsu: a byte-addressed reference memory predicts
// load results; a word memory model answers the DUT's request/response port.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int AW  = 11;
  localparam int AW2 = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic v1, v2, rd, wr, zext;
  logic [1:0]  wid;
  logic [31:0] addr, wdat;

  logic stall1, wbv1, lm1, sm1, rqv1, ready1, rspv1;
  logic [31:0] rdata1, fa1, rqd1, rspd1;
  logic [AW-1:0] rqa1;
  logic [3:0] rqb1;

  logic stall2, wbv2, lm2, sm2, rqv2, ready2, rspv2;
  logic [31:0] rdata2, fa2, rqd2, rspd2;
  logic [AW2-1:0] rqa2;
  logic [3:0] rqb2;

  mem_lsu #(.MEM_ADDR_W(AW), .MISALIGN_SPLIT(1)) u_dut (
    .clk(clk), .rst(rst),
    .ex_mb__valid(v1), .ex_mb__dmem_read(rd), .ex_mb__dmem_write(wr),
    .ex_mb__dmem_width(wid), .ex_mb__dmem_zero_ext(zext),
    .ex_mb__addr(addr), .ex_mb__wdata(wdat),
    .lsu_stall(stall1), .mb_wb__valid(wbv1), .mb_wb__rdata(rdata1),
    .mb_wb__load_misalign(lm1), .mb_wb__store_misalign(sm1), .mb_wb__fault_addr(fa1),
    .mem_req_valid(rqv1), .mem_req_ready(ready1), .mem_req_addr(rqa1),
    .mem_req_writeb(rqb1), .mem_req_wdata(rqd1),
    .mem_rsp_valid(rspv1), .mem_rsp_rdata(rspd1)
  );

  mem_lsu #(.MEM_ADDR_W(AW2), .MISALIGN_SPLIT(0)) u_dut_fault (
    .clk(clk), .rst(rst),
    .ex_mb__valid(v2), .ex_mb__dmem_read(rd), .ex_mb__dmem_write(wr),
    .ex_mb__dmem_width(wid), .ex_mb__dmem_zero_ext(zext),
    .ex_mb__addr(addr), .ex_mb__wdata(wdat),
    .lsu_stall(stall2), .mb_wb__valid(wbv2), .mb_wb__rdata(rdata2),
    .mb_wb__load_misalign(lm2), .mb_wb__store_misalign(sm2), .mb_wb__fault_addr(fa2),
    .mem_req_valid(rqv2), .mem_req_ready(ready2), .mem_req_addr(rqa2),
    .mem_req_writeb(rqb2), .mem_req_wdata(rqd2),
    .mem_rsp_valid(rspv2), .mem_rsp_rdata(rspd2)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] mem  [2**AW];
  logic [7:0]  refm [2**(AW+2)];

  typedef struct packed {
    logic [31:0] rdata;
    logic        chk_rd;
    logic        lm;
    logic        sm;
    logic [31:0] fa;
  } exp_t;
  exp_t sb1[$];
  exp_t sb2[$];

  typedef struct packed {
    logic [AW-1:0] a;
    logic [3:0]    b;
    logic [31:0]   d;
  } req_t;
  req_t rq_exp[$];

  int ready_mode;
  bit zero_wait, spurious_en, hold_rsp, req_chk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] w);
    case (w)
      ENCDEC_BYTE: return 1;
      ENCDEC_HALF: return 2;
      default:     return 4;
    endcase
  endfunction

  function automatic int bidx(input logic [31:0] a, input int i);
    logic [31:0] s;
    s = a + 32'(i);
    return int'(s[AW+1:0]);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] w, input logic z);
    logic [31:0] v;
    int n;
    v = 32'h0;
    n = nbytes(w);
    for (int i = 0; i < n; i++) v[8*i +: 8] = refm[bidx(a, i)];
    if (!z && v[8*n-1])
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
    for (int i = 0; i < nbytes(w); i++) refm[bidx(a, i)] = d[8*i +: 8];
  endtask

  task automatic preload(input int wa, input logic [31:0] val);
    mem[wa] = val;
    for (int i = 0; i < 4; i++) refm[wa*4 + i] = val[8*i +: 8];
  endtask

  // Word memory behind the DUT port: random ready, 0-2 cycle read latency,
  // stray rsp_valid pulses while nothing is outstanding.
  initial begin : memory_model
    bit pend;
    int dly;
    logic [31:0] pdata;
    bit hold_v;
    logic [AW-1:0] hold_a;
    logic [3:0] hold_b;
    logic [31:0] hold_d;
    req_t e;
    pend = 0; dly = 0; pdata = 0; hold_v = 0; hold_a = 0; hold_b = 0; hold_d = 0;
    ready1 = 1'b0; rspv1 = 1'b0; rspd1 = 32'h0;
    forever begin
      @(posedge clk); #1;
      rspv1 = 1'b0;
      rspd1 = $urandom;
      if (pend && !hold_rsp) begin
        if (dly == 0) begin
          rspv1 = 1'b1;
          rspd1 = pdata;
          pend  = 0;
        end else dly--;
      end else if (!pend && spurious_en && $urandom_range(0, 7) == 0) begin
        rspv1 = 1'b1;
      end
      if (hold_v) begin
        check("req_hold_valid", 32'(rqv1), 32'h1);
        check("req_hold_addr", 32'(rqa1), 32'(hold_a));
        check("req_hold_writeb", 32'(rqb1), 32'(hold_b));
        check("req_hold_wdata", rqd1, hold_d);
      end
      if (ready_mode == 1)      ready1 = 1'b1;
      else if (ready_mode == 2) ready1 = 1'b0;
      else                      ready1 = ($urandom_range(0, 3) != 0);
      hold_v = rqv1 && !ready1;
      hold_a = rqa1; hold_b = rqb1; hold_d = rqd1;
      if (rqv1 && ready1) begin
        if (req_chk) begin
          if (rq_exp.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_req actual=%h required=none", rqa1);
          end else begin
            e = rq_exp.pop_front();
            check("req_addr", 32'(rqa1), 32'(e.a));
            check("req_writeb", 32'(rqb1), 32'(e.b));
            check("req_wdata", rqd1, e.d);
          end
        end
        if (rqb1 == 4'b0000) begin
          pend  = 1;
          pdata = mem[rqa1];
          dly   = zero_wait ? 0 : $urandom_range(0, 2);
        end else begin
          for (int b = 0; b < 4; b++)
            if (rqb1[b]) mem[rqa1][8*b +: 8] = rqd1[8*b +: 8];
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (v1 && (rd || wr)) check("stall1", 32'(stall1), 32'(!wbv1));
        if (v2 && (rd || wr)) check("stall2", 32'(stall2), 32'(!wbv2));
        if (v2) check("fault_no_req", 32'(rqv2), 32'h0);
        if (wbv1) begin
          if (sb1.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_wb1 actual=1 required=0");
          end else begin
            e = sb1.pop_front();
            if (e.chk_rd) check("rdata", rdata1, e.rdata);
            check("lm1", 32'(lm1), 32'h0);
            check("sm1", 32'(sm1), 32'h0);
          end
        end
        if (wbv2) begin
          if (sb2.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_wb2 actual=1 required=0");
          end else begin
            e = sb2.pop_front();
            check("fault_rdata", rdata2, e.rdata);
            check("load_misalign", 32'(lm2), 32'(e.lm));
            check("store_misalign", 32'(sm2), 32'(e.sm));
            check("fault_addr", fa2, e.fa);
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after completion.
  task automatic do_op(input logic r, input logic w, input logic [1:0] ww, input logic z,
                       input logic [31:0] a, input logic [31:0] d, input int lat,
                       input bit use_c, input logic [31:0] cval);
    exp_t e;
    int n;
    bit got;
    rd = r; wr = w; wid = ww; zext = z; addr = a; wdat = d; v1 = 1'b1;
    e = '0;
    if (r) begin
      e.rdata  = use_c ? cval : ref_load(a, ww, z);
      e.chk_rd = 1'b1;
    end else ref_store(a, ww, d);
    sb1.push_back(e);
    n = 0; got = 0;
    while (!got && n < 64) begin
      @(negedge clk);
      if (wbv1) got = 1; else n++;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL op_timeout actual=none required=valid addr=%h", a);
    end else if (lat >= 0) check("latency", 32'(n), 32'(lat));
    @(posedge clk); #1;
    v1 = 1'b0;
  endtask

  task automatic do_op2(input logic r, input logic [1:0] ww, input logic [31:0] a);
    exp_t e;
    int n;
    bit got;
    rd = r; wr = !r; wid = ww; zext = 1'b0; addr = a; wdat = $urandom; v2 = 1'b1;
    e = '0;
    e.lm = r; e.sm = !r; e.fa = a;
    sb2.push_back(e);
    n = 0; got = 0;
    while (!got && n < 16) begin
      @(negedge clk);
      if (wbv2) got = 1; else n++;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL fault_timeout actual=none required=valid addr=%h", a);
    end else check("fault_latency", 32'(n), 32'h1);
    @(posedge clk); #1;
    v2 = 1'b0;
  endtask

  task automatic do_nop();
    rd = 1'b0; wr = 1'b0; v1 = 1'b1;
    @(negedge clk);
    check("nop_stall", 32'(stall1), 32'h0);
    @(posedge clk); #1;
    v1 = 1'b0;
  endtask

  initial begin : stimulus
    int n, sel;
    logic r_i, w_i;
    logic [31:0] a_i;
    v1 = 0; v2 = 0; rd = 0; wr = 0; wid = 0; zext = 0; addr = 0; wdat = 0;
    ready2 = 1'b1; rspv2 = 1'b0; rspd2 = 32'h0;
    ready_mode = 1; zero_wait = 1; spurious_en = 0; hold_rsp = 0; req_chk = 1;
    for (int i = 0; i < 2**AW; i++) preload(i, $urandom);

    rst = 1'b1;
    rd = 1'b1; v1 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_stall", 32'(stall1), 32'h0);
    check("rst_req_valid", 32'(rqv1), 32'h0);
    check("rst_wb_valid", 32'(wbv1), 32'h0);
    check("rst_rdata", rdata1, 32'h0);
    check("rst_fault_addr", fa2, 32'h0);
    v1 = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    rq_exp.push_back('{a: 11'h040, b: 4'hF, d: 32'hDEADBEEF});
    do_op(0, 1, ENCDEC_WORD, 0, 32'h100, 32'hDEADBEEF, 2, 0, 0);
    check("store_mem", mem[11'h040], 32'hDEADBEEF);

    preload(32'h40, 32'h80112233);
    rq_exp.push_back('{a: 11'h040, b: 4'h0, d: 32'h0});
    do_op(1, 0, ENCDEC_BYTE, 0, 32'h103, 32'h0, 3, 1, 32'hFFFFFF80);
    rq_exp.push_back('{a: 11'h040, b: 4'h0, d: 32'h0});
    do_op(1, 0, ENCDEC_BYTE, 1, 32'h103, 32'h0, 3, 1, 32'h00000080);

    rq_exp.push_back('{a: 11'h040, b: 4'b1100, d: 32'hCCDD0000});
    rq_exp.push_back('{a: 11'h041, b: 4'b0011, d: 32'h0000AABB});
    do_op(0, 1, ENCDEC_WORD, 0, 32'h102, 32'hAABBCCDD, 3, 0, 0);
    rq_exp.push_back('{a: 11'h040, b: 4'h0, d: 32'h0});
    rq_exp.push_back('{a: 11'h041, b: 4'h0, d: 32'h0});
    do_op(1, 0, ENCDEC_WORD, 0, 32'h102, 32'h0, 5, 1, 32'hAABBCCDD);

    preload(32'h7FF, 32'h12000000);
    preload(32'h000, 32'h00000034);
    rq_exp.push_back('{a: 11'h7FF, b: 4'h0, d: 32'h0});
    rq_exp.push_back('{a: 11'h000, b: 4'h0, d: 32'h0});
    do_op(1, 0, ENCDEC_HALF, 0, 32'h1FFF, 32'h0, 5, 1, 32'h00003412);
    check("req_queue_drained", 32'(rq_exp.size()), 32'h0);

    do_op2(1, ENCDEC_WORD, 32'h101);
    do_op2(0, ENCDEC_HALF, 32'h203);
    do_op2(1, ENCDEC_HALF, 32'h7FF);

    // Back-pressured request, then reset while the response is outstanding.
    req_chk = 0;
    @(negedge clk);
    ready_mode = 2; hold_rsp = 1;
    preload(32'h50, 32'h0BADF00D);
    @(posedge clk); #1;
    rd = 1'b1; wr = 1'b0; wid = ENCDEC_WORD; zext = 1'b0; addr = 32'h140; v1 = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("stall_held", 32'(stall1), 32'h1);
    end
    check("req_held_addr", 32'(rqa1), 32'h050);
    ready_mode = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rqv1 && n < 20);
    check("in_rsp_stall", 32'(stall1), 32'h1);
    rst = 1'b1;
    #1;
    check("midrst_stall", 32'(stall1), 32'h0);
    check("midrst_req_valid", 32'(rqv1), 32'h0);
    check("midrst_wb_valid", 32'(wbv1), 32'h0);
    check("midrst_rdata", rdata1, 32'h0);
    @(posedge clk); #1;
    v1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    hold_rsp = 0;
    repeat (6) begin
      @(negedge clk);
      check("no_wb_after_rst", 32'(wbv1), 32'h0);
    end

    @(posedge clk); #1;
    ready_mode = 0; zero_wait = 0; spurious_en = 1;
    repeat (400) begin
      sel = $urandom_range(0, 19);
      if (sel == 0) do_nop();
      else begin
        r_i = 1'($urandom_range(0, 1));
        w_i = !r_i;
        if (sel == 1) begin r_i = 1'b1; w_i = 1'b1; end
        if (sel < 14)      a_i = 32'($urandom_range(0, 47));
        else if (sel < 17) a_i = 32'h1FF0 + 32'($urandom_range(0, 15));
        else               a_i = $urandom;
        do_op(r_i, w_i, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
              a_i, $urandom, -1, 0, 32'h0);
      end
    end

    repeat (4) @(negedge clk);
    check("sb1_drained", 32'(sb1.size()), 32'h0);
    check("sb2_drained", 32'(sb2.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
